pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Owns the architectural program counter and sequences instruction fetch.
- Each cycle it picks the next PC: sequential (pc+1), conditional branch (BrA), jump-register (RAA) or unconditional jump (BrA). The choice follows the team's BS/PS/zero branch encoding.
- After a taken redirect it drives a squash window that kills wrong-path fetches. It also handles hazard stalls and instruction-memory back-pressure.
- Sits between the execute-stage branch resolution and the instruction memory port.

Parameters:
- ADDR_W, 32, PC/target width.
- RESET_PC, 0, PC value loaded on reset.
- BR_PENALTY, 2, length in cycles of the squash window after a taken redirect; legal range 1..7.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard hold; freezes PC advance.
- br_valid  in  1  execute stage presents a branch resolution this cycle.
- bs  in  2  branch select: 00 seq, 01 conditional, 10 jump-register, 11 jump.
- ps  in  1  branch polarity.
- zero  in  1  ALU zero flag.
- bra  in  ADDR_W  branch/jump target.
- raa  in  ADDR_W  register jump target.
- imem_ready  in  1  instruction memory accepts the request this cycle.
- imem_req  out  1  fetch request for address pc.
- pc  out  ADDR_W  current fetch address (registered).
- if_valid  out  1  the fetch accepted this cycle is correct-path.
- flush  out  1  downstream must discard IF/ID contents.
- redirect  out  1  taken redirect this cycle (combinational).
- redirect_cnt  out  16  saturating count of taken redirects.

Behaviour:
- Taken decode (combinational):
  - taken = br_valid & (bs==11 | bs==10 | (bs==01 & (ps^zero))).
  - bs==00 is never taken.
  - Target = raa when bs==10, otherwise bra.
- redirect = taken. A redirect is raised in every state except BOOT.
- Reset (async, rst=1): pc=RESET_PC, state=BOOT, sq_cnt=0, redirect_cnt=0. Outputs imem_req, if_valid and flush are 0 while reset is held.
- States:
  - BOOT: imem_req=0, flush=0, if_valid=0. br_valid is ignored. Go to RUN on the next edge.
  - RUN: imem_req=1. flush=redirect. if_valid = imem_ready & ~stall & ~redirect.
  - SQUASH: imem_req=1, if_valid=0, flush=1.
- Accept = imem_req & imem_ready & ~stall.
- PC update priority, highest first:
  1. redirect (RUN or SQUASH): pc <= target, regardless of stall or imem_ready. Then state <= SQUASH, sq_cnt <= BR_PENALTY-1. If BR_PENALTY==1, state <= RUN instead.
  2. Accept, no redirect: pc <= pc+1, with modulo 2^ADDR_W wrap (all-ones wraps to 0).
  3. Otherwise pc holds.
- SQUASH exit:
  - sq_cnt decrements every cycle, independent of stall and imem_ready.
  - When sq_cnt==0 and there is no redirect, state <= RUN next edge.
  - Flush window total (redirect cycle included) = BR_PENALTY cycles.
- Redirect inside SQUASH: the new target wins and sq_cnt reloads to BR_PENALTY-1. The window restarts from that cycle.
- PC advance during SQUASH: pc still advances on accept. These fetches are on the new path and only the returned slots are killed.
- redirect_cnt:
  - Increments on each redirect cycle.
  - Saturates at 16'hFFFF.
  - Cleared only by rst.
- Reset asserted mid-SQUASH or mid-stall: immediate return to reset values. The first request after release comes one cycle later, from BOOT.

Test Plan:
1. Reset release, imem_ready=1, stall=0 -> cycle 0 BOOT, imem_req=0. pc sequence then 0,1,2,3 with if_valid=1 each cycle.
2. At pc=5, br_valid=1, bs=01, ps=0, zero=1, bra=0x40 -> redirect=1 and flush=1 that cycle. Next pc=0x40. flush stays high 1 further cycle (BR_PENALTY=2), then pc=0x41, 0x42 with if_valid=1. Repeat with zero=0 -> no redirect, pc=6.
3. bs=10, raa=0x100, bra=0x40, with stall=1 and imem_ready=0 the same cycle -> pc=0x100 next cycle. Redirect overrides stall. redirect_cnt increments.
4. stall=1 for 3 cycles in RUN -> pc frozen, if_valid=0, imem_req=1. imem_ready=0 gives the same result.
5. Second redirect (bs=11, bra=0x80) one cycle into SQUASH -> pc=0x80, flush window restarts for a full BR_PENALTY cycles.
6. RESET_PC = all-ones with ADDR_W=8 -> pc wraps 0xFF→0x00. Also force redirect_cnt to 0xFFFF; a further redirect holds 0xFFFF. Assert rst mid-SQUASH -> flush=0, pc=RESET_PC immediately.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter sequencer: picks the next fetch address from sequential, branch and
// jump sources, and opens a squash window after every taken redirect.
module pc_sequencer #(
   parameter int unsigned        ADDR_W     = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
   parameter int unsigned        BR_PENALTY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              br_valid,
   input  logic [1:0]        bs,
   input  logic              ps,
   input  logic              zero,
   input  logic [ADDR_W-1:0] bra,
   input  logic [ADDR_W-1:0] raa,
   input  logic              imem_ready,
   output logic              imem_req,
   output logic [ADDR_W-1:0] pc,
   output logic              if_valid,
   output logic              flush,
   output logic              redirect,
   output logic [15:0]       redirect_cnt
);

   localparam int unsigned SQ_W  = 3;
   localparam int unsigned CNT_W = 16;
   localparam logic [SQ_W-1:0]  SQ_LOAD = SQ_W'(BR_PENALTY - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      SQUASH = 2'd2
   } state_t;

   state_t            state;
   logic [SQ_W-1:0]   sq_cnt;
   logic              taken;
   logic              accept;
   logic [ADDR_W-1:0] target;

   // Branch decode: 01 conditional on ps^zero, 10/11 always taken, 00 never
   always_comb begin
      taken = 1'b0;
      if (br_valid) begin
         case (bs)
            2'b01:   taken = ps ^ zero;
            2'b10,
            2'b11:   taken = 1'b1;
            default: taken = 1'b0;
         endcase
      end
   end

   assign target   = (bs == 2'b10) ? raa : bra;
   assign redirect = taken & (state != BOOT);
   assign imem_req = (state != BOOT);
   assign accept   = imem_req & imem_ready & ~stall;
   assign flush    = (state == SQUASH) | ((state == RUN) & redirect);
   assign if_valid = (state == RUN) & imem_ready & ~stall & ~redirect;

   // A redirect wins over stall and back-pressure; fetches inside the window still advance pc
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= BOOT;
         pc           <= RESET_PC;
         sq_cnt       <= '0;
         redirect_cnt <= '0;
      end else begin
         if (redirect && (redirect_cnt != CNT_MAX))
            redirect_cnt <= redirect_cnt + CNT_W'(1);

         case (state)
            BOOT: state <= RUN;
            default: begin
               if (redirect) begin
                  pc     <= target;
                  sq_cnt <= SQ_LOAD;
                  state  <= (BR_PENALTY > 1) ? SQUASH : RUN;
               end else begin
                  if (accept)
                     pc <= pc + ADDR_W'(1);
                  if (state == SQUASH) begin
                     if (sq_cnt != '0)
                        sq_cnt <= sq_cnt - SQ_W'(1);
                     // Last squash cycle is the one that sees the count expire
                     if (sq_cnt <= SQ_W'(1))
                        state <= RUN;
                  end
               end
            end
         endcase
      end
   end

endmodule
